// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------+
// | regfile_pkg : shared constants and types for the regfile write-back  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int MAX_WAIT = 3;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_ctrl_if.sv
// +----------------------------------------------------------------------+
// | regfile_wb_ctrl_if : requester, issue and write-port signal bundle   |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

interface regfile_wb_ctrl_if #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
);
    logic                inhibit_in;
    logic                alu_valid_in;
    logic [ADDR_W-1:0]   alu_rd_in;
    logic [DATA_W-1:0]   alu_data_in;
    logic                alu_ready_out;
    logic                mem_valid_in;
    logic [ADDR_W-1:0]   mem_rd_in;
    logic [DATA_W-1:0]   mem_data_in;
    logic                mem_ready_out;
    logic                issue_valid_in;
    logic [ADDR_W-1:0]   issue_rd_in;
    logic [NUM_REGS-1:0] busy_out;
    logic                we_reg_out;
    logic [ADDR_W-1:0]   rd_out;
    logic [DATA_W-1:0]   data_out;
    logic                init_done_out;

    modport slave (
        input  inhibit_in,
        input  alu_valid_in, alu_rd_in, alu_data_in,
        output alu_ready_out,
        input  mem_valid_in, mem_rd_in, mem_data_in,
        output mem_ready_out,
        input  issue_valid_in, issue_rd_in,
        output busy_out, we_reg_out, rd_out, data_out, init_done_out
    );

    modport master (
        output inhibit_in,
        output alu_valid_in, alu_rd_in, alu_data_in,
        input  alu_ready_out,
        output mem_valid_in, mem_rd_in, mem_data_in,
        input  mem_ready_out,
        output issue_valid_in, issue_rd_in,
        input  busy_out, we_reg_out, rd_out, data_out, init_done_out
    );

endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// +----------------------------------------------------------------------+
// | regfile_scoreboard : pending-write bitmask, set wins over clear      |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard #(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_set_en,
    input  wire logic [ADDR_W-1:0]   i_set_idx,
    input  wire logic                i_clr_en,
    input  wire logic [ADDR_W-1:0]   i_clr_idx,
    output      logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear applied first so a same-register set in the same cycle overrides it.
    always_comb begin
        busy_d = busy_q;
        if (i_clr_en) begin
            busy_d[i_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            busy_d[i_set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
// +----------------------------------------------------------------------+
// | regfile_wb_ctrl : clears the regfile, then arbitrates ALU/load writes|
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int MAX_WAIT = regfile_pkg::MAX_WAIT
) (
    input  wire logic         clka,
    input  wire logic         reset_n_in,
    regfile_wb_ctrl_if.slave  bus
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    wb_state_e           state_q,     state_d;
    logic [ADDR_W-1:0]   clr_cnt_q,   clr_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic                we_q,        we_d;
    logic [ADDR_W-1:0]   rd_q,        rd_d;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic                init_done_q, init_done_d;

    logic w_run;
    logic w_grant_ok;
    logic w_starved;
    logic w_alu_ready;
    logic w_mem_ready;
    logic w_alu_xfer;
    logic w_mem_xfer;
    logic [ADDR_W-1:0] w_clr_idx;

    // Grants are withheld while reset is low so no handshake completes into a dropped write.
    always_comb begin
        w_run       = (state_q == RUN);
        w_grant_ok  = w_run & ~bus.inhibit_in & reset_n_in;
        w_starved   = (wait_cnt_q == WAIT_W'(MAX_WAIT));
        w_mem_ready = w_grant_ok & bus.mem_valid_in & ~(w_starved & bus.alu_valid_in);
        w_alu_ready = w_grant_ok & bus.alu_valid_in & (~bus.mem_valid_in | w_starved);
        w_alu_xfer  = bus.alu_valid_in & w_alu_ready;
        w_mem_xfer  = bus.mem_valid_in & w_mem_ready;
        w_clr_idx   = w_alu_xfer ? bus.alu_rd_in : bus.mem_rd_in;
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = 1'b0;
        rd_d        = rd_q;
        data_d      = data_q;
        init_done_d = w_run;

        if (state_q == CLEAR) begin
            we_d      = 1'b1;
            rd_d      = clr_cnt_q;
            data_d    = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                state_d = RUN;
            end
        end else begin
            if (w_alu_xfer) begin
                we_d   = 1'b1;
                rd_d   = bus.alu_rd_in;
                data_d = bus.alu_data_in;
            end else if (w_mem_xfer) begin
                we_d   = 1'b1;
                rd_d   = bus.mem_rd_in;
                data_d = bus.mem_data_in;
            end

            if (w_alu_xfer) begin
                wait_cnt_d = '0;
            end else if (w_grant_ok && bus.alu_valid_in && !w_starved) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (!reset_n_in) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clka),
        .rst_n     (reset_n_in),
        .i_set_en  (w_run & bus.issue_valid_in),
        .i_set_idx (bus.issue_rd_in),
        .i_clr_en  (w_alu_xfer | w_mem_xfer),
        .i_clr_idx (w_clr_idx),
        .o_busy    (bus.busy_out)
    );

    assign bus.alu_ready_out = w_alu_ready;
    assign bus.mem_ready_out = w_mem_ready;
    assign bus.we_reg_out    = we_q;
    assign bus.rd_out        = rd_q;
    assign bus.data_out      = data_q;
    assign bus.init_done_out = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_regfile_wb_ctrl : directed bench for the regfile write-back ctrl  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wb_ctrl;

    logic clka;
    logic reset_n_in;
    int   checks;
    int   errors;

    regfile_wb_ctrl_if bus ();

    regfile_wb_ctrl dut (
        .clka       (clka),
        .reset_n_in (reset_n_in),
        .bus        (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inhibit_in     = 1'b0;
        bus.alu_valid_in   = 1'b0;
        bus.alu_rd_in      = '0;
        bus.alu_data_in    = '0;
        bus.mem_valid_in   = 1'b0;
        bus.mem_rd_in      = '0;
        bus.mem_data_in    = '0;
        bus.issue_valid_in = 1'b0;
        bus.issue_rd_in    = '0;
    endtask

    task automatic check_clear_seq(input string tag);
        for (int i = 0; i < 8; i++) begin
            step();
            chk({tag, "_we"},   32'(bus.we_reg_out),    32'd1);
            chk({tag, "_rd"},   32'(bus.rd_out),        32'(i));
            chk({tag, "_data"}, 32'(bus.data_out),      32'd0);
            chk({tag, "_idone"},32'(bus.init_done_out), 32'd0);
            if (i == 7) begin
                idle_inputs();
            end else begin
                chk({tag, "_alu_rdy"}, 32'(bus.alu_ready_out), 32'd0);
                chk({tag, "_mem_rdy"}, 32'(bus.mem_ready_out), 32'd0);
            end
        end
        step();
        chk({tag, "_idone9"}, 32'(bus.init_done_out), 32'd1);
        chk({tag, "_we9"},    32'(bus.we_reg_out),    32'd0);
        chk({tag, "_busy9"},  32'(bus.busy_out),      32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset_n_in = 1'b0;

        // Requesters and issue active during reset/CLEAR must be ignored.
        bus.alu_valid_in   = 1'b1; bus.alu_rd_in = 3'd6; bus.alu_data_in = 8'hEE;
        bus.mem_valid_in   = 1'b1; bus.mem_rd_in = 3'd2; bus.mem_data_in = 8'hDD;
        bus.issue_valid_in = 1'b1; bus.issue_rd_in = 3'd1;
        step();
        chk("rst_we",    32'(bus.we_reg_out),    32'd0);
        chk("rst_rd",    32'(bus.rd_out),        32'd0);
        chk("rst_data",  32'(bus.data_out),      32'd0);
        chk("rst_idone", 32'(bus.init_done_out), 32'd0);
        chk("rst_busy",  32'(bus.busy_out),      32'd0);
        chk("rst_alu_rdy", 32'(bus.alu_ready_out), 32'd0);
        reset_n_in = 1'b1;
        check_clear_seq("clr");

        // Lone ALU request, then the same request under inhibit.
        bus.alu_valid_in = 1'b1; bus.alu_rd_in = 3'd3; bus.alu_data_in = 8'h5A;
        #1;
        chk("alu_rdy", 32'(bus.alu_ready_out), 32'd1);
        chk("alu_mem_rdy", 32'(bus.mem_ready_out), 32'd0);
        step();
        chk("alu_we",   32'(bus.we_reg_out), 32'd1);
        chk("alu_rd",   32'(bus.rd_out),     32'd3);
        chk("alu_data", 32'(bus.data_out),   32'h5A);
        bus.inhibit_in = 1'b1;
        #1;
        chk("inh_alu_rdy", 32'(bus.alu_ready_out), 32'd0);
        step();
        chk("inh_we",   32'(bus.we_reg_out), 32'd0);
        chk("inh_rd",   32'(bus.rd_out),     32'd3);
        chk("inh_data", 32'(bus.data_out),   32'h5A);
        idle_inputs();

        // Both held: memory wins 3 times, then the starved ALU, then memory again.
        bus.alu_valid_in = 1'b1; bus.alu_rd_in = 3'd1; bus.alu_data_in = 8'h11;
        bus.mem_valid_in = 1'b1; bus.mem_rd_in = 3'd2; bus.mem_data_in = 8'h22;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("arb_mem_rdy", 32'(bus.mem_ready_out), 32'd1);
            chk("arb_alu_rdy", 32'(bus.alu_ready_out), 32'd0);
            step();
            chk("arb_mem_rd",   32'(bus.rd_out),   32'd2);
            chk("arb_mem_data", 32'(bus.data_out), 32'h22);
        end
        #1;
        chk("starve_alu_rdy", 32'(bus.alu_ready_out), 32'd1);
        chk("starve_mem_rdy", 32'(bus.mem_ready_out), 32'd0);
        step();
        chk("starve_we",   32'(bus.we_reg_out), 32'd1);
        chk("starve_rd",   32'(bus.rd_out),     32'd1);
        chk("starve_data", 32'(bus.data_out),   32'h11);
        bus.mem_rd_in = 3'd4; bus.mem_data_in = 8'h44;
        #1;
        chk("after_mem_rdy", 32'(bus.mem_ready_out), 32'd1);
        chk("after_alu_rdy", 32'(bus.alu_ready_out), 32'd0);
        step();
        chk("after_rd",   32'(bus.rd_out),   32'd4);
        chk("after_data", 32'(bus.data_out), 32'h44);
        idle_inputs();
        step();
        chk("idle_we", 32'(bus.we_reg_out), 32'd0);

        // Scoreboard set, clear, and same-cycle set-wins.
        bus.issue_valid_in = 1'b1; bus.issue_rd_in = 3'd5;
        step();
        idle_inputs();
        chk("sb_set", 32'(bus.busy_out), 32'h20);
        bus.alu_valid_in = 1'b1; bus.alu_rd_in = 3'd5; bus.alu_data_in = 8'h77;
        step();
        idle_inputs();
        chk("sb_clr", 32'(bus.busy_out), 32'h00);
        chk("sb_clr_rd", 32'(bus.rd_out), 32'd5);
        bus.issue_valid_in = 1'b1; bus.issue_rd_in = 3'd5;
        step();
        chk("sb_set2", 32'(bus.busy_out), 32'h20);
        bus.alu_valid_in = 1'b1; bus.alu_rd_in = 3'd5; bus.alu_data_in = 8'h78;
        #1;
        chk("sb_both_rdy", 32'(bus.alu_ready_out), 32'd1);
        step();
        idle_inputs();
        chk("sb_setwins", 32'(bus.busy_out), 32'h20);

        // Reset during CLEAR after the write to reg 3.
        reset_n_in = 1'b0;
        step();
        chk("r1_busy", 32'(bus.busy_out),   32'd0);
        chk("r1_we",   32'(bus.we_reg_out), 32'd0);
        reset_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r1_clr_rd", 32'(bus.rd_out), 32'(i));
        end
        reset_n_in = 1'b0;
        step();
        chk("r2_we", 32'(bus.we_reg_out), 32'd0);
        chk("r2_rd", 32'(bus.rd_out),     32'd0);
        reset_n_in = 1'b1;
        check_clear_seq("reclr");

        // Reset while an ALU write and issue are presented in RUN.
        bus.issue_valid_in = 1'b1; bus.issue_rd_in = 3'd2;
        step();
        chk("r3_busy_pre", 32'(bus.busy_out), 32'h04);
        bus.issue_valid_in = 1'b0;
        bus.alu_valid_in = 1'b1; bus.alu_rd_in = 3'd6; bus.alu_data_in = 8'hC3;
        reset_n_in = 1'b0;
        step();
        chk("r3_we",   32'(bus.we_reg_out), 32'd0);
        chk("r3_rd",   32'(bus.rd_out),     32'd0);
        chk("r3_data", 32'(bus.data_out),   32'd0);
        chk("r3_busy", 32'(bus.busy_out),   32'd0);
        idle_inputs();
        reset_n_in = 1'b1;
        step();
        chk("r3_clr_we", 32'(bus.we_reg_out), 32'd1);
        chk("r3_clr_rd", 32'(bus.rd_out),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
